// File: rtl/pc_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-side next-PC unit.
package pc_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_4180;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDefer = 2'd1,
        StIsr   = 2'd2
    } pc_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_ctrl.sv
// Owns the IF program counter: selects the next PC among interrupt, branch, ERET, jump,
// stall and sequential flow, and raises the flushes and EPC capture each redirect needs.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET_DEFAULT,
    parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallIf,
    input  logic        BranchEx,
    input  logic [31:0] BrTargetEx,
    input  logic        JumpId,
    input  logic [31:0] JTargetId,
    input  logic        ERetId,
    input  logic [31:0] EPCIn,
    input  logic        IntReq,
    input  logic [31:0] PCId,
    input  logic        ValidId,
    output logic [31:0] PCIf,
    output logic [31:0] PCPlus4If,
    output logic        FlushIfId,
    output logic        FlushIdEx,
    output logic        EPCWr,
    output logic [31:0] EPCOut,
    output logic        IntAck
);

    logic [31:0] r_pc;
    pc_state_e   r_state;

    logic [31:0] w_pc_next;
    pc_state_e   w_state_next;
    logic        w_redirect;
    logic        w_int_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= StRun;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_redirect   = BranchEx | JumpId | ERetId;
        // The handler is never nested; a pending request waits behind any redirect.
        w_int_take   = (r_state != StIsr) && IntReq && !w_redirect;

        w_pc_next    = pc_plus4(r_pc);
        w_state_next = r_state;
        FlushIfId    = 1'b0;
        FlushIdEx    = 1'b0;
        EPCWr        = 1'b0;
        EPCOut       = 32'h0;
        IntAck       = 1'b0;

        if (w_int_take) begin
            w_pc_next    = INT_VECTOR;
            w_state_next = StIsr;
            FlushIfId    = 1'b1;
            FlushIdEx    = 1'b1;
            EPCWr        = 1'b1;
            IntAck       = 1'b1;
            EPCOut       = ValidId ? PCId : r_pc;
        end else begin
            if (BranchEx) begin
                w_pc_next = BrTargetEx;
                FlushIfId = 1'b1;
                FlushIdEx = 1'b1;
            end else if (ERetId) begin
                w_pc_next = EPCIn;
                FlushIfId = 1'b1;
            end else if (JumpId) begin
                w_pc_next = JTargetId;
                FlushIfId = 1'b1;
            end else if (StallIf) begin
                w_pc_next = r_pc;
            end

            if (r_state == StIsr) begin
                // A branch in the same cycle squashes the ERET, so only an unsquashed one exits.
                if (ERetId && !BranchEx) begin
                    w_state_next = StRun;
                end
            end else if (IntReq && w_redirect) begin
                w_state_next = StDefer;
            end else begin
                w_state_next = StRun;
            end
        end

        if (rst) begin
            FlushIfId = 1'b0;
            FlushIdEx = 1'b0;
            EPCWr     = 1'b0;
            EPCOut    = 32'h0;
            IntAck    = 1'b0;
        end
    end

    assign PCIf      = r_pc;
    assign PCPlus4If = pc_plus4(r_pc);

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, hand sequences and random stimulus
// against a behavioural model of the next-PC priority rules.
module tb_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] VEC_PC = 32'h0000_4180;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        eret;
        logic [31:0] epcin;
        logic        intreq;
        logic [31:0] pcid;
        logic        vid;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] pc;
        logic        fif;
        logic        fidex;
        logic        ack;
        logic [31:0] epcout;
    } row_t;

    logic        clk = 1'b0;
    logic        rst, StallIf, BranchEx, JumpId, ERetId, IntReq, ValidId;
    logic [31:0] BrTargetEx, JTargetId, EPCIn, PCId;
    logic [31:0] PCIf, PCPlus4If, EPCOut;
    logic        FlushIfId, FlushIdEx, EPCWr, IntAck;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 = normal, 1 = interrupt waiting behind a redirect, 2 = in handler.
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] e_npc, e_epcout;
    logic        e_fif, e_fidex, e_ack;
    int          e_nmode;

    row_t rows[$];

    pc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .StallIf   (StallIf),
        .BranchEx  (BranchEx),
        .BrTargetEx(BrTargetEx),
        .JumpId    (JumpId),
        .JTargetId (JTargetId),
        .ERetId    (ERetId),
        .EPCIn     (EPCIn),
        .IntReq    (IntReq),
        .PCId      (PCId),
        .ValidId   (ValidId),
        .PCIf      (PCIf),
        .PCPlus4If (PCPlus4If),
        .FlushIfId (FlushIfId),
        .FlushIdEx (FlushIdEx),
        .EPCWr     (EPCWr),
        .EPCOut    (EPCOut),
        .IntAck    (IntAck)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(logic stall, logic br, logic [31:0] brt, logic j,
                                 logic [31:0] jt, logic eret, logic [31:0] epcin,
                                 logic intreq, logic [31:0] pcid, logic vid);
        vec_t v;
        v.rst = 1'b0; v.stall = stall; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
        v.eret = eret; v.epcin = epcin; v.intreq = intreq; v.pcid = pcid; v.vid = vid;
        return v;
    endfunction

    function automatic row_t mkrow(vec_t v, logic [31:0] pc, logic fif, logic fidex,
                                   logic ack, logic [31:0] epcout);
        row_t r;
        r.v = v; r.pc = pc; r.fif = fif; r.fidex = fidex; r.ack = ack; r.epcout = epcout;
        return r;
    endfunction

    task automatic drive(vec_t v);
        rst = v.rst; StallIf = v.stall; BranchEx = v.br; BrTargetEx = v.brt;
        JumpId = v.j; JTargetId = v.jt; ERetId = v.eret; EPCIn = v.epcin;
        IntReq = v.intreq; PCId = v.pcid; ValidId = v.vid;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs and next model state from the priority list, using current inputs.
    task automatic model_eval();
        logic redirect;
        redirect = BranchEx | JumpId | ERetId;
        e_fif = 0; e_fidex = 0; e_ack = 0; e_epcout = 0;
        e_npc = m_pc + 32'd4; e_nmode = m_mode;
        if (rst) begin
            e_npc = RST_PC; e_nmode = 0;
        end else if (m_mode != 2 && IntReq && !redirect) begin
            e_npc = VEC_PC; e_nmode = 2; e_fif = 1; e_fidex = 1; e_ack = 1;
            e_epcout = ValidId ? PCId : m_pc;
        end else begin
            if (BranchEx) begin
                e_npc = BrTargetEx; e_fif = 1; e_fidex = 1;
            end else if (ERetId) begin
                e_npc = EPCIn; e_fif = 1;
            end else if (JumpId) begin
                e_npc = JTargetId; e_fif = 1;
            end else if (StallIf) begin
                e_npc = m_pc;
            end
            if (m_mode == 2) e_nmode = (ERetId && !BranchEx) ? 0 : 2;
            else             e_nmode = (IntReq && redirect) ? 1 : 0;
        end
    endtask

    task automatic check_vs_model(string tag);
        model_eval();
        chk({tag, ".PCIf"}, PCIf, m_pc);
        chk({tag, ".PCPlus4If"}, PCPlus4If, m_pc + 32'd4);
        chk({tag, ".FlushIfId"}, {31'd0, FlushIfId}, {31'd0, e_fif});
        chk({tag, ".FlushIdEx"}, {31'd0, FlushIdEx}, {31'd0, e_fidex});
        chk({tag, ".EPCWr"}, {31'd0, EPCWr}, {31'd0, e_ack});
        chk({tag, ".IntAck"}, {31'd0, IntAck}, {31'd0, e_ack});
        chk({tag, ".EPCOut"}, EPCOut, e_epcout);
    endtask

    task automatic advance();
        @(posedge clk);
        model_eval();
        m_pc = e_npc;
        m_mode = e_nmode;
    endtask

    task automatic step(vec_t v, string tag);
        @(negedge clk);
        drive(v);
        #1;
        check_vs_model(tag);
        advance();
    endtask

    initial begin
        vec_t v;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_pc = RST_PC;
        m_mode = 0;

        for (int i = 0; i < 4; i++)
            rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), RST_PC + 32'(4 * i), 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(1,0,0,0,0,0,0,0,0,0), 32'h3010, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(1,0,0,0,0,0,0,0,0,0), 32'h3010, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), 32'h3010, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), 32'h3014, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), 32'h3018, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), 32'h301C, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(1,1,32'h3100,0,0,0,0,0,0,0), 32'h3020, 1, 1, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,1,32'h3028,0,0,0,0,0), 32'h3100, 1, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,1,32'h3024,1), 32'h3028, 1, 1, 1, 32'h3024));
        rows.push_back(mkrow(mkv(0,0,0,1,32'h4200,0,0,1,0,0), 32'h4180, 1, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,1,32'h3024,0,0,0), 32'h4200, 1, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,1,32'h3200,0,0,1,0,1), 32'h3024, 1, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,1,32'h1234,0), 32'h3200, 1, 1, 1, 32'h3200));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), 32'h4180, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,1,32'h5000,1,32'h6000,0,0,0,0,0), 32'h4184, 1, 1, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,1,32'h3001,0,0,0), 32'h5000, 1, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,0,0,0), 32'h3001, 0, 0, 0, 0));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,1,0,0), 32'h3005, 1, 1, 1, 32'h3005));
        rows.push_back(mkrow(mkv(0,0,0,0,0,0,0,1,32'h2222,1), 32'h4180, 0, 0, 0, 0));

        foreach (rows[i]) begin
            @(negedge clk);
            drive(rows[i].v);
            #1;
            chk($sformatf("row%0d.PCIf", i), PCIf, rows[i].pc);
            chk($sformatf("row%0d.PCPlus4If", i), PCPlus4If, rows[i].pc + 32'd4);
            chk($sformatf("row%0d.FlushIfId", i), {31'd0, FlushIfId}, {31'd0, rows[i].fif});
            chk($sformatf("row%0d.FlushIdEx", i), {31'd0, FlushIdEx}, {31'd0, rows[i].fidex});
            chk($sformatf("row%0d.IntAck", i), {31'd0, IntAck}, {31'd0, rows[i].ack});
            chk($sformatf("row%0d.EPCWr", i), {31'd0, EPCWr}, {31'd0, rows[i].ack});
            chk($sformatf("row%0d.EPCOut", i), EPCOut, rows[i].epcout);
            advance();
        end

        // Reset while in the handler with a request pending.
        @(negedge clk);
        v = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v.rst = 1'b1;
        drive(v);
        #1;
        chk("rst_isr.IntAck", {31'd0, IntAck}, 32'd0);
        chk("rst_isr.EPCWr", {31'd0, EPCWr}, 32'd0);
        advance();
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_isr.PCIf", PCIf, RST_PC);
        chk("rst_isr.ack_after", {31'd0, IntAck}, 32'd0);
        advance();
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 1, 32'h2FF0, 1));
        #1;
        chk("rst_run.IntAck", {31'd0, IntAck}, 32'd1);
        chk("rst_run.EPCOut", EPCOut, 32'h2FF0);
        advance();

        // Deferral dropped: request falls away behind a branch, no ack follows.
        step(mkv(0, 0, 0, 0, 0, 1, 32'h3100, 0, 0, 0), "eret_exit");
        step(mkv(0, 1, 32'h3300, 0, 0, 0, 0, 1, 0, 0), "defer_br");
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("defer_drop.PCIf", PCIf, 32'h3300);
        chk("defer_drop.IntAck", {31'd0, IntAck}, 32'd0);
        advance();

        // Fetch address wrap-around.
        step(mkv(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0), "wrap_jmp");
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("wrap.PCPlus4If", PCPlus4If, 32'h0);
        advance();
        @(negedge clk);
        #1;
        chk("wrap.PCIf", PCIf, 32'h0);
        advance();

        for (int n = 0; n < 600; n++) begin
            v.rst    = ($urandom_range(0, 99) < 2);
            v.stall  = ($urandom_range(0, 3) == 0);
            v.br     = ($urandom_range(0, 6) == 0);
            v.brt    = $urandom;
            v.j      = ($urandom_range(0, 6) == 0);
            v.jt     = $urandom;
            v.eret   = ($urandom_range(0, 9) == 0);
            v.epcin  = $urandom;
            v.intreq = $urandom_range(0, 1) == 1;
            v.pcid   = $urandom;
            v.vid    = $urandom_range(0, 1) == 1;
            step(v, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-side next-PC and control-transfer unit. It owns the PC register that feeds IF.
- Consumes BranchEx and its target from EX, plus jump and ERET from ID.
- Arbitrates interrupt entry, including EPC capture, against those redirects.
- Generates the pipeline flushes the redirects require.
- Branches resolve in EX and the machine has no delay slot, so a taken branch squashes the IF and ID instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- INT_VECTOR, 32'h0000_4180, interrupt handler entry address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- StallIf  in  1  load-use hold from the hazard unit; hold the PC.
- BranchEx  in  1  branch taken, from the EX branch decision.
- BrTargetEx  in  32  branch target computed in EX.
- JumpId  in  1  J/JAL/JR/JALR decoded in ID.
- JTargetId  in  32  jump target from ID.
- ERetId  in  1  ERET decoded in ID.
- EPCIn  in  32  current EPC from CP0.
- IntReq  in  1  level request from CP0 (pending & mask & IE).
- PCId  in  32  PC of the instruction in ID.
- ValidId  in  1  ID holds a real (non-bubble) instruction.
- PCIf  out  32  current fetch address.
- PCPlus4If  out  32  PCIf + 4.
- FlushIfId  out  1  clear the IF/ID register this cycle.
- FlushIdEx  out  1  clear the ID/EX register this cycle.
- EPCWr  out  1  one-cycle write strobe to CP0 EPC.
- EPCOut  out  32  value to write into EPC.
- IntAck  out  1  one-cycle pulse when the vector is taken.

Behaviour:
- Reset values (when rst is high at a clock edge):
  - PCIf = RESET_PC and state = RUN.
  - All strobe and flush outputs are 0 and EPCOut = 0.
  - Reset overrides everything, including mid-ISR and a pending deferral.
- PCPlus4If is combinational: PCIf + 4, mod 2^32 (wrap-around allowed, no trap).
- Redirect outputs (FlushIfId, FlushIdEx, EPCWr, IntAck) are combinational from the current cycle's decision. The PC updates at the next edge.
- State machine:
  - RUN: normal operation.
  - DEFER: an interrupt is pending behind a redirect.
  - ISR: in the handler; IntReq is ignored.
- Next-PC priority, highest first:
  1. Interrupt taken. Occurs in state RUN or DEFER, with IntReq=1, BranchEx=0, JumpId=0 and ERetId=0.
     - PC <= INT_VECTOR.
     - FlushIfId = 1 and FlushIdEx = 1.
     - EPCWr = 1 and IntAck = 1.
     - EPCOut = PCId if ValidId, else PCIf.
     - state <= ISR.
  2. BranchEx. PC <= BrTargetEx; FlushIfId = 1 and FlushIdEx = 1.
  3. ERetId. PC <= EPCIn; FlushIfId = 1. If in ISR, state <= RUN.
  4. JumpId. PC <= JTargetId; FlushIfId = 1.
  5. StallIf. PC holds; no flushes.
  6. Otherwise PC <= PC + 4.
- Redirects override StallIf. The stalled ID instruction is either squashed (branch) or is itself the jump/ERET; in both cases its redirect is valid now.
- Simultaneous IntReq with BranchEx, JumpId or ERetId:
  - The redirect wins and state <= DEFER. This keeps EPC pointing at a non-squashed instruction.
  - From DEFER, the interrupt is taken on the first cycle with no redirect. EPC then equals the redirect target sitting in ID or IF.
- DEFER with IntReq deasserted: return to RUN without an ack.
- BranchEx and JumpId together (older EX instruction vs younger ID instruction): the branch wins and the jump is squashed.
- ISR: IntReq is ignored (no nesting). Only ERetId or rst leaves ISR. ERetId seen outside ISR still redirects to EPCIn.
- PC alignment: no alignment checks are made; bits [1:0] pass through unchanged.

Decomposition:
- Shared package / global definitions:
  - RESET_PC and INT_VECTOR defaults.
  - State encoding: RUN=2'd0, DEFER=2'd1, ISR=2'd2.
- No sub-module. One sequential block holds PC and state; one combinational block does next-PC selection and flushes.

Test Plan:
- Reset then 3 free-running cycles -> PCIf = 3000, 3004, 3008, 300C; no flushes.
- PCIf=3010, StallIf=1 for 2 cycles, then released -> PCIf holds 3010 for 2 cycles, then 3014.
- At PCIf=3020: BranchEx=1, BrTargetEx=3100, and StallIf=1 in the same cycle -> FlushIfId = FlushIdEx = 1; next PCIf = 3100.
- Interrupt with no redirect:
  - Stimulus: IntReq=1 with ValidId=1, PCId=3024, PCIf=3028.
  - Response: IntAck=1, EPCWr=1, EPCOut=3024, both flushes=1; next PCIf = 4180, state = ISR.
  - Follow-on: IntReq held, JumpId=1, JTargetId=4200 -> no second ack; next PCIf = 4200.
  - Follow-on: ERetId=1 with EPCIn=3024 -> FlushIfId=1; next PCIf = 3024, state = RUN.
- Deferred interrupt:
  - Stimulus: IntReq=1 and JumpId=1 (JTargetId=3200) in the same cycle.
  - Response: jump taken, no ack, state = DEFER.
  - Next cycle (ValidId=0, PCIf=3200): IntAck=1, EPCOut=3200; next PCIf = 4180.
- Reset in the middle of the ISR -> PCIf = 3000, state = RUN, IntAck = 0.
